// File: rtl/d_cache_nway_wb.sv
// rtl/d_cache_nway_wb.sv - N-way write-back, write-allocate data cache with word-by-word line transfers
module d_cache_nway_wb #(
    parameter int WAY_WIDTH   = 1,
    parameter int INDEX_WIDTH = 6,
    parameter int WORD_WIDTH  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int WAYS  = 1 << WAY_WIDTH;
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << WORD_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH - WORD_WIDTH - 2;
    localparam int WW    = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

    typedef enum logic [1:0] {IDLE, WB, RF, DONE} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0]      tag_mem  [WAYS][SETS];
    logic [31:0]           data_mem [WAYS][SETS][WORDS];
    logic [WAYS-1:0]       valid    [SETS];
    logic [WAYS-1:0]       dirty    [SETS];
    logic [WW-1:0]         rr       [SETS];

    logic [WORD_WIDTH-1:0]  cnt;
    logic [WW-1:0]          victim, victim_sel, hit_way, serve_way, rr_inc;
    logic [WAYS-1:0]        hit_vec;
    logic                   pending, hit, serve, beat_done, last_beat;
    logic [TAG_W-1:0]       req_tag, line_tag;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [WORD_WIDTH-1:0]  req_word;
    logic [3:0]             bmask;
    logic [31:0]            merged;

    assign req_tag  = cpu_data_addr[31 -: TAG_W];
    assign req_idx  = cpu_data_addr[INDEX_WIDTH+WORD_WIDTH+1 -: INDEX_WIDTH];
    assign req_word = cpu_data_addr[WORD_WIDTH+1 -: WORD_WIDTH];

    // Descending scan so the lowest-numbered invalid way ends up as the victim.
    always_comb begin
        hit_vec    = '0;
        hit_way    = '0;
        victim_sel = rr[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid[req_idx][w] && (tag_mem[w][req_idx] == req_tag);
            if (hit_vec[w]) hit_way = WW'(w);
            if (!valid[req_idx][w]) victim_sel = WW'(w);
        end
    end

    assign hit       = |hit_vec;
    assign serve     = (state == DONE) || (state == IDLE && cpu_data_req && hit);
    assign serve_way = (state == DONE) ? victim : hit_way;
    assign rr_inc    = (WAY_WIDTH == 0) ? '0 : rr[req_idx] + 1'b1;

    assign cpu_data_addr_ok = serve;
    assign cpu_data_data_ok = serve;
    assign cpu_data_rdata   = serve ? data_mem[serve_way][req_idx][req_word] : '0;

    assign cache_data_req   = (state == WB || state == RF) && !pending;
    assign cache_data_wr    = cache_data_req && (state == WB);
    assign cache_data_size  = 2'b10;
    assign line_tag         = (state == WB) ? tag_mem[victim][req_idx] : req_tag;
    assign cache_data_addr  = cache_data_req ? {line_tag, req_idx, cnt, 2'b00} : '0;
    assign cache_data_wdata = cache_data_wr ? data_mem[victim][req_idx][cnt] : '0;
    assign beat_done        = (state == WB || state == RF) && cache_data_data_ok;
    assign last_beat        = &cnt;

    always_comb begin
        bmask  = 4'b1111;
        merged = cpu_data_rdata;
        case (cpu_data_size)
            2'd0:    bmask = 4'b0001 << cpu_data_addr[1:0];
            2'd1:    bmask = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
            default: bmask = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = bmask[b] ? cpu_data_wdata[8*b +: 8] : cpu_data_rdata[8*b +: 8];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cpu_data_req && !hit)
                      state_nxt = (valid[req_idx][victim_sel] && dirty[req_idx][victim_sel]) ? WB : RF;
            WB:   if (beat_done && last_beat) state_nxt = RF;
            RF:   if (beat_done && last_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt wraps to zero after the last beat, so each phase starts from word 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            victim  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                rr[s]    <= '0;
            end
        end else begin
            state   <= state_nxt;
            pending <= (pending | (cache_data_req & cache_data_addr_ok)) & ~cache_data_data_ok;
            if (state == IDLE && cpu_data_req && !hit) begin
                victim <= victim_sel;
                cnt    <= '0;
            end
            if (beat_done) cnt <= cnt + 1'b1;
            if (state == RF && beat_done && last_beat) begin
                valid[req_idx][victim] <= 1'b1;
                dirty[req_idx][victim] <= 1'b0;
                if (valid[req_idx][victim]) rr[req_idx] <= rr_inc;
            end
            if (serve && cpu_data_wr) dirty[req_idx][serve_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RF && beat_done) begin
            data_mem[victim][req_idx][cnt] <= cache_data_rdata;
            if (last_beat) tag_mem[victim][req_idx] <= req_tag;
        end
        if (serve && cpu_data_wr)
            data_mem[serve_way][req_idx][req_word] <= merged;
    end
endmodule

// File: tb/tb_d_cache_nway_wb.sv
// tb/tb_d_cache_nway_wb.sv - directed checks of the N-way write-back data cache
`timescale 1ns/1ps
module tb_d_cache_nway_wb;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_data_req = 1'b0, cpu_data_wr = 1'b0;
    logic [1:0]  cpu_data_size = 2'd0;
    logic [31:0] cpu_data_addr = '0, cpu_data_wdata = '0;
    logic [31:0] cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata;
    logic [31:0] cache_data_rdata = '0;
    logic        cache_data_addr_ok = 1'b0, cache_data_data_ok = 1'b0;

    int n_chk = 0, n_fail = 0;
    int addr_dly = 0, data_dly = 0, b_cnt = 0, proto_err = 0, ok_pair_err = 0;
    logic        b_busy = 1'b0;
    logic [31:0] b_addr = '0, bridge_base = '0;
    logic [31:0] log_addr[$], log_wdata[$];
    logic        log_wr[$];

    d_cache_nway_wb dut (
        .clk(clk), .resetn(resetn),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
        .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
        .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
        .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr), .cache_data_size(cache_data_size),
        .cache_data_addr(cache_data_addr), .cache_data_wdata(cache_data_wdata),
        .cache_data_rdata(cache_data_rdata), .cache_data_addr_ok(cache_data_addr_ok),
        .cache_data_data_ok(cache_data_data_ok)
    );

    always #5 clk = ~clk;

    // Bridge responder: one beat at a time, refill word = bridge_base + word offset.
    initial begin
        forever begin
            @(negedge clk);
            cache_data_addr_ok = 1'b0;
            cache_data_data_ok = 1'b0;
            if (!resetn) begin
                b_busy = 1'b0;
                b_cnt  = 0;
            end else if (!b_busy) begin
                if (cache_data_req) begin
                    if (cache_data_size !== 2'b10) proto_err++;
                    if (b_cnt == addr_dly) begin
                        cache_data_addr_ok = 1'b1;
                        b_busy = 1'b1;
                        b_cnt  = 0;
                        b_addr = cache_data_addr;
                        log_addr.push_back(cache_data_addr);
                        log_wr.push_back(cache_data_wr);
                        log_wdata.push_back(cache_data_wdata);
                    end else b_cnt++;
                end else if (b_cnt != 0) begin
                    proto_err++;
                    b_cnt = 0;
                end
            end else begin
                if (cache_data_req) proto_err++;
                if (b_cnt == data_dly) begin
                    cache_data_data_ok = 1'b1;
                    cache_data_rdata   = bridge_base + {30'd0, b_addr[3:2]};
                    b_busy = 1'b0;
                    b_cnt  = 0;
                end else b_cnt++;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_wr.delete();
        log_wdata.delete();
    endtask

    task automatic cpu_start(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = sz; cpu_data_addr = a; cpu_data_wdata = wd;
    endtask

    task automatic cpu_wait(output logic [31:0] rd, output int cyc);
        rd  = 32'hDEAD_DEAD;
        cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cpu_data_addr_ok !== cpu_data_data_ok) ok_pair_err++;
            if (cpu_data_data_ok === 1'b1) begin
                rd  = cpu_data_rdata;
                cyc = i;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_data_req = 1'b0;
        cpu_data_wr  = 1'b0;
    endtask

    task automatic cpu_access(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        cpu_start(wr, sz, a, wd);
        cpu_wait(rd, cyc);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cpu_data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (cache_data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", cache_data_req); end
        n_chk++; if (cache_data_size !== 2'b10) begin n_fail++; $display("FAIL reset_size: got %b want 10", cache_data_size); end
        n_chk++; if (cpu_data_data_ok !== 1'b0 || cpu_data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b%b want 00", cpu_data_addr_ok, cpu_data_data_ok); end
        n_chk++; if (cpu_data_rdata !== 32'h0 || cache_data_addr !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", cpu_data_rdata, cache_data_addr); end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_cold_load();
        logic [31:0] rd; int cyc;
        do_reset();
        bridge_base = 32'hA0;
        cpu_access(1'b0, 2'd2, 32'h0000_1004, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'hA1) begin n_fail++; $display("FAIL cold_rdata: got %h want %h", rd, 32'hA1); end
        n_chk++; if (cyc !== 9) begin n_fail++; $display("FAIL cold_latency: got %0d want 9", cyc); end
        n_chk++; if (log_addr.size() !== 4) begin n_fail++; $display("FAIL cold_beats: got %0d want 4", log_addr.size()); end
        if (log_addr.size() == 4)
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (log_addr[i] !== 32'h1000 + 32'(4 * i) || log_wr[i] !== 1'b0) begin
                    n_fail++; $display("FAIL cold_beat%0d: got %h wr=%b want %h wr=0", i, log_addr[i], log_wr[i], 32'h1000 + 32'(4 * i));
                end
            end
        cpu_access(1'b0, 2'd2, 32'h0000_1008, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'hA2 || cyc !== 0) begin n_fail++; $display("FAIL reload_hit: got %h in %0d want %h in 0", rd, cyc, 32'hA2); end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd; int cyc;
        cpu_access(1'b1, 2'd0, 32'h0000_1001, 32'h0000_5A00, rd, cyc);
        n_chk++; if (cyc !== 0) begin n_fail++; $display("FAIL store_byte_latency: got %0d want 0", cyc); end
        cpu_access(1'b0, 2'd2, 32'h0000_1000, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h0000_5AA0 || cyc !== 0) begin n_fail++; $display("FAIL store_byte_merge: got %h in %0d want 00005aa0 in 0", rd, cyc); end
        n_chk++; if (log_addr.size() !== 4) begin n_fail++; $display("FAIL store_hit_traffic: got %0d beats want 4", log_addr.size()); end
    endtask

    task automatic test_evict_dirty();
        logic [31:0] rd, exp_a, exp_d; int cyc;
        do_reset();
        bridge_base = 32'h100; cpu_access(1'b0, 2'd2, 32'h0000_0000, 32'h0, rd, cyc);
        bridge_base = 32'h200; cpu_access(1'b0, 2'd2, 32'h0000_0400, 32'h0, rd, cyc);
        cpu_access(1'b1, 2'd2, 32'h0000_0000, 32'h1234_5678, rd, cyc);
        clear_log();
        bridge_base = 32'h300;
        cpu_access(1'b0, 2'd2, 32'h0000_0800, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h300 || cyc !== 17) begin n_fail++; $display("FAIL dirty_miss: got %h in %0d want 00000300 in 17", rd, cyc); end
        n_chk++; if (log_addr.size() !== 8) begin n_fail++; $display("FAIL dirty_beats: got %0d want 8", log_addr.size()); end
        if (log_addr.size() == 8)
            for (int i = 0; i < 8; i++) begin
                exp_a = (i < 4) ? 32'(4 * i) : 32'h800 + 32'(4 * (i - 4));
                exp_d = (i == 0) ? 32'h1234_5678 : 32'h100 + 32'(i);
                n_chk++;
                if (log_addr[i] !== exp_a || log_wr[i] !== (i < 4) || (i < 4 && log_wdata[i] !== exp_d)) begin
                    n_fail++; $display("FAIL dirty_beat%0d: got %h wr=%b d=%h want %h wr=%b d=%h", i, log_addr[i], log_wr[i], log_wdata[i], exp_a, (i < 4), exp_d);
                end
            end
    endtask

    task automatic test_evict_clean();
        logic [31:0] rd; int cyc;
        clear_log();
        bridge_base = 32'h400;
        cpu_access(1'b0, 2'd2, 32'h0000_0C04, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h401 || cyc !== 9) begin n_fail++; $display("FAIL clean_miss: got %h in %0d want 00000401 in 9", rd, cyc); end
        n_chk++; if (log_addr.size() !== 4 || log_wr[0] !== 1'b0 || log_addr[0] !== 32'h0C00) begin n_fail++; $display("FAIL clean_beats: got %0d first %h want 4 first 00000c00 reads", log_addr.size(), log_addr[0]); end
        cpu_access(1'b0, 2'd2, 32'h0000_0800, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h300 || cyc !== 0) begin n_fail++; $display("FAIL survivor_hit: got %h in %0d want 00000300 in 0", rd, cyc); end
        cpu_access(1'b1, 2'd1, 32'h0000_0802, 32'hBEEF_0000, rd, cyc);
        cpu_access(1'b0, 2'd2, 32'h0000_0800, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'hBEEF_0300 || cyc !== 0) begin n_fail++; $display("FAIL half_merge: got %h in %0d want beef0300 in 0", rd, cyc); end
    endtask

    task automatic test_slow_bridge();
        logic [31:0] rd; int cyc;
        do_reset();
        addr_dly = 3; data_dly = 2;
        bridge_base = 32'h500;
        cpu_access(1'b0, 2'd2, 32'h0000_2000, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h500 || cyc !== 29 || log_addr.size() !== 4) begin n_fail++; $display("FAIL slow_fill: got %h in %0d beats %0d want 00000500 in 29 beats 4", rd, cyc, log_addr.size()); end
        cpu_access(1'b1, 2'd2, 32'h0000_2004, 32'hCAFE_F00D, rd, cyc);
        bridge_base = 32'h600;
        cpu_access(1'b0, 2'd2, 32'h0000_2400, 32'h0, rd, cyc);
        clear_log();
        bridge_base = 32'h700;
        cpu_access(1'b0, 2'd2, 32'h0000_2800, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h700 || cyc !== 57 || log_addr.size() !== 8) begin n_fail++; $display("FAIL slow_dirty: got %h in %0d beats %0d want 00000700 in 57 beats 8", rd, cyc, log_addr.size()); end
        n_chk++; if (log_wr[0] !== 1'b1 || log_addr[0] !== 32'h2000 || log_wdata[1] !== 32'hCAFE_F00D || log_wr[4] !== 1'b0 || log_addr[4] !== 32'h2800) begin
            n_fail++; $display("FAIL slow_dirty_beats: got %h/%b %h %h/%b", log_addr[0], log_wr[0], log_wdata[1], log_addr[4], log_wr[4]);
        end
        addr_dly = 0; data_dly = 0;
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] rd; int cyc;
        do_reset();
        bridge_base = 32'h600;
        cpu_start(1'b0, 2'd2, 32'h0000_3004, 32'h0);
        for (int i = 0; i < 100 && log_addr.size() < 3; i++) begin
            @(posedge clk); #2;
        end
        n_chk++; if (log_addr.size() !== 3) begin n_fail++; $display("FAIL midmiss_reach_beat2: got %0d beats want 3", log_addr.size()); end
        resetn = 1'b0;
        @(posedge clk); #2 resetn = 1'b1;
        clear_log();
        bridge_base = 32'h700;
        cpu_wait(rd, cyc);
        n_chk++; if (rd !== 32'h701 || cyc !== 9) begin n_fail++; $display("FAIL midmiss_refill: got %h in %0d want 00000701 in 9", rd, cyc); end
        n_chk++; if (log_addr.size() !== 4 || log_addr[0] !== 32'h3000) begin n_fail++; $display("FAIL midmiss_beats: got %0d first %h want 4 first 00003000", log_addr.size(), log_addr[0]); end
        cpu_access(1'b0, 2'd2, 32'h0000_3004, 32'h0, rd, cyc);
        n_chk++; if (rd !== 32'h701 || cyc !== 0) begin n_fail++; $display("FAIL midmiss_rehit: got %h in %0d want 00000701 in 0", rd, cyc); end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_evict_dirty();
        test_evict_clean();
        test_slow_bridge();
        test_reset_mid_miss();
        n_chk++; if (proto_err !== 0) begin n_fail++; $display("FAIL bridge_protocol: got %0d violations want 0", proto_err); end
        n_chk++; if (ok_pair_err !== 0) begin n_fail++; $display("FAIL ok_pairing: got %0d mismatches want 0", ok_pair_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
